// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the RAT CPU hazard/interrupt sequencer
package pipeline_ctrl_pkg;
  localparam int REG_AW = 5;
  localparam logic [1:0] LOAD_SEL = 2'b01;
  typedef enum logic [1:0] {RUN, FLUSH, INTR_DRAIN, INTR_INJ} hazard_state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading a register that the EX-stage load has not yet produced
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] i_x_addr,
  input  logic [REG_AW-1:0] i_y_addr,
  input  logic              i_uses_x,
  input  logic              i_uses_y,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic              i_rf_wr,
  input  logic [1:0]        i_rf_wr_sel,
  output logic              o_load_hazard
);
  assign o_load_hazard = i_rf_wr && (i_rf_wr_sel == LOAD_SEL) &&
                         ((i_uses_x && i_x_addr == i_wb_addr) || (i_uses_y && i_y_addr == i_wb_addr));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/nop/interrupt sequencer feeding IF/ID, PC and the ID/EX control register
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int INTR_DRAIN_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_X_ADDR,
  input  logic [REG_AW-1:0] id_Y_ADDR,
  input  logic              id_uses_x,
  input  logic              id_uses_y,
  input  logic [REG_AW-1:0] ex_WB_ADDR,
  input  logic              ex_RF_WR,
  input  logic [1:0]        ex_RF_WR_SEL,
  input  logic              ex_branch_taken,
  input  logic              intr_req,
  input  logic              i_flag,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              nop,
  output logic              interupt,
  output logic              intr_ack
);
  localparam int MAXC = (BRANCH_FLUSH_CYCLES > INTR_DRAIN_CYCLES) ? BRANCH_FLUSH_CYCLES : INTR_DRAIN_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BR_RELOAD = CW'((BRANCH_FLUSH_CYCLES > 1) ? BRANCH_FLUSH_CYCLES - 2 : 0);
  localparam logic [CW-1:0] DR_RELOAD = CW'(INTR_DRAIN_CYCLES - 1);

  hazard_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_intr_pending, w_pend_nxt, w_load_hazard;

  load_use_detect u_load_use (
    .i_x_addr      (id_X_ADDR),
    .i_y_addr      (id_Y_ADDR),
    .i_uses_x      (id_uses_x),
    .i_uses_y      (id_uses_y),
    .i_wb_addr     (ex_WB_ADDR),
    .i_rf_wr       (ex_RF_WR),
    .i_rf_wr_sel   (ex_RF_WR_SEL),
    .o_load_hazard (w_load_hazard)
  );

  // latch interrupt requests while enabled; drop them when disabled in RUN or once injected
  always_comb
    w_pend_nxt = (r_state == INTR_INJ || (r_state == RUN && !i_flag)) ? 1'b0 :
                 (intr_req && i_flag) ? 1'b1 : r_intr_pending;

  // sequencer state, countdown and pending-interrupt registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_intr_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_intr_pending <= w_pend_nxt;
    end
  end

  // next state and same-cycle control outputs; branch beats load hazard beats interrupt
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    {pc_stall, ifid_stall, ifid_flush, nop, interupt, intr_ack} = '0;
    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          nop        = 1'b1;
          if (BRANCH_FLUSH_CYCLES > 1) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = BR_RELOAD;
          end
        end else if (w_load_hazard) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          nop        = 1'b1;
        end else if (r_intr_pending && i_flag) begin
          pc_stall    = 1'b1;
          ifid_flush  = 1'b1;
          w_state_nxt = INTR_DRAIN;
          w_cnt_nxt   = DR_RELOAD;
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        nop        = 1'b1;
        if (ex_branch_taken) w_cnt_nxt = BR_RELOAD;
        else if (r_cnt == '0) w_state_nxt = RUN;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      INTR_DRAIN: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        nop        = ex_branch_taken;
        if (ex_branch_taken) w_cnt_nxt = DR_RELOAD;
        else if (r_cnt == '0) w_state_nxt = INTR_INJ;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      default: begin
        interupt    = 1'b1;
        intr_ack    = 1'b1;
        ifid_flush  = 1'b1;
        w_state_nxt = RUN;
      end
    endcase
    if (rst) {pc_stall, ifid_stall, ifid_flush, nop, interupt, intr_ack} = '0;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against a cycle-count reference model
module tb_pipeline_hazard_ctrl;
  localparam int B = 2;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_X_ADDR, id_Y_ADDR, ex_WB_ADDR;
  logic       id_uses_x, id_uses_y, ex_RF_WR, ex_branch_taken, intr_req, i_flag;
  logic [1:0] ex_RF_WR_SEL;
  logic       pc_stall, ifid_stall, ifid_flush, nop, interupt, intr_ack;

  int n_cmp = 0;
  int n_bad = 0;
  int m_flush, m_drain;
  bit m_inj, m_pend;
  int n_int, n_ps;
  logic [5:0] obs;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.BRANCH_FLUSH_CYCLES(B), .INTR_DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .id_X_ADDR(id_X_ADDR), .id_Y_ADDR(id_Y_ADDR), .id_uses_x(id_uses_x), .id_uses_y(id_uses_y),
    .ex_WB_ADDR(ex_WB_ADDR), .ex_RF_WR(ex_RF_WR), .ex_RF_WR_SEL(ex_RF_WR_SEL),
    .ex_branch_taken(ex_branch_taken), .intr_req(intr_req), .i_flag(i_flag),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .nop(nop), .interupt(interupt), .intr_ack(intr_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {pc_stall, ifid_stall, ifid_flush, nop, interupt, intr_ack};
  endfunction

  task automatic m_reset();
    m_flush = 0;
    m_drain = 0;
    m_inj   = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic clr();
    {ex_branch_taken, ex_RF_WR, intr_req, id_uses_x, id_uses_y} = '0;
    ex_RF_WR_SEL = 2'b00;
    ex_WB_ADDR = '0;
    id_X_ADDR = '0;
    id_Y_ADDR = '0;
  endtask

  // caller drives inputs just after a falling edge; this checks mid-cycle then commits the model at the rising edge
  task automatic step(input string tag);
    bit hz, in_run, ps, is, fl, np, it, ak, ni, npend;
    int nf, nd;
    #1;
    hz = ex_RF_WR && ex_RF_WR_SEL == 2'b01 &&
         ((id_uses_x && id_X_ADDR == ex_WB_ADDR) || (id_uses_y && id_Y_ADDR == ex_WB_ADDR));
    {ps, is, fl, np, it, ak, ni} = '0;
    nf = m_flush;
    nd = m_drain;
    npend = m_pend;
    in_run = !m_inj && m_drain == 0 && m_flush == 0;
    if (m_inj) begin
      it = 1; ak = 1; fl = 1;
    end else if (m_drain > 0) begin
      ps = 1; fl = 1; np = ex_branch_taken;
      nd = ex_branch_taken ? D : m_drain - 1;
      ni = (nd == 0);
    end else if (m_flush > 0) begin
      fl = 1; np = 1;
      nf = ex_branch_taken ? B - 1 : m_flush - 1;
    end else if (ex_branch_taken) begin
      fl = 1; np = 1; nf = B - 1;
    end else if (hz) begin
      ps = 1; is = 1; np = 1;
    end else if (m_pend && i_flag) begin
      ps = 1; fl = 1; nd = D;
    end
    if (m_inj) npend = 0;
    else if (in_run && !i_flag) npend = 0;
    else if (intr_req && i_flag) npend = 1;
    obs = outs();
    chk(tag, obs, {ps, is, fl, np, it, ak});
    if (obs[1]) n_int++;
    if (obs[5]) n_ps++;
    @(posedge clk);
    m_flush = nf;
    m_drain = nd;
    m_inj   = ni;
    m_pend  = npend;
  endtask

  task automatic pulse_intr();
    @(negedge clk); clr(); i_flag = 1; intr_req = 1; step("intr_pulse");
  endtask

  initial begin
    rst = 1; clr(); i_flag = 1; ex_branch_taken = 1; m_reset();
    #2 chk("reset_outs", 32'(outs()), 0);
    repeat (2) @(negedge clk);
    rst = 0; clr();

    // load-use stall, then clear
    @(negedge clk); clr(); ex_RF_WR = 1; ex_RF_WR_SEL = 2'b01; ex_WB_ADDR = 5; id_X_ADDR = 5; id_uses_x = 1;
    step("t1_hz");
    chk("t1_hz_vec", 32'(obs), 32'b110100);
    @(negedge clk); clr(); step("t1_after");
    chk("t1_after_vec", 32'(obs), 0);

    // branch flush with coincident hazard
    @(negedge clk); ex_branch_taken = 1; ex_RF_WR = 1; ex_RF_WR_SEL = 2'b01; ex_WB_ADDR = 7; id_Y_ADDR = 7; id_uses_y = 1;
    step("t2_br");
    chk("t2_br_vec", 32'(obs), 32'b001100);
    @(negedge clk); ex_branch_taken = 0; step("t2_flush");
    chk("t2_flush_vec", 32'(obs), 32'b001100);
    @(negedge clk); clr(); step("t2_done");
    chk("t2_done_vec", 32'(obs), 0);

    // single interrupt pulse
    n_int = 0; n_ps = 0;
    pulse_intr();
    for (int i = 0; i < 8; i++) begin @(negedge clk); clr(); step("t3_seq"); end
    chk("t3_int_count", n_int, 1);
    chk("t3_stall_count", n_ps, 3);

    // disabled interrupt ignored, then enabled with request held
    n_int = 0; n_ps = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); clr(); i_flag = 0; intr_req = 1; step("t4_off"); end
    chk("t4_off_int", n_int, 0);
    chk("t4_off_stall", n_ps, 0);
    for (int i = 0; i < 6; i++) begin @(negedge clk); clr(); i_flag = 1; intr_req = 1; step("t4_on"); end
    chk("t4_on_int", n_int, 1);
    for (int i = 0; i < 2; i++) begin @(negedge clk); clr(); i_flag = 0; step("t4_drop"); end

    // branch during the second drain cycle restarts the drain
    n_int = 0; n_ps = 0;
    pulse_intr();
    for (int i = 0; i < 2; i++) begin @(negedge clk); clr(); step("t5_pre"); end
    @(negedge clk); clr(); ex_branch_taken = 1; step("t5_br");
    chk("t5_br_vec", 32'(obs), 32'b101100);
    for (int i = 0; i < 6; i++) begin @(negedge clk); clr(); step("t5_post"); end
    chk("t5_int_count", n_int, 1);
    chk("t5_stall_count", n_ps, 5);

    // asynchronous reset in the middle of a drain
    pulse_intr();
    for (int i = 0; i < 2; i++) begin @(negedge clk); clr(); step("t6_pre"); end
    @(negedge clk); rst = 1; #1 chk("t6_async", 32'(outs()), 0);
    m_reset();
    @(negedge clk); rst = 0;
    n_int = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); clr(); step("t6_post"); end
    chk("t6_int_count", n_int, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(199) == 0) begin
        rst = 1; #1 chk("rnd_rst", 32'(outs()), 0);
        m_reset();
        @(negedge clk); rst = 0;
      end
      id_X_ADDR = 5'($urandom_range(3));
      id_Y_ADDR = 5'($urandom_range(3));
      ex_WB_ADDR = 5'($urandom_range(3));
      id_uses_x = 1'($urandom);
      id_uses_y = 1'($urandom);
      ex_RF_WR = 1'($urandom);
      ex_RF_WR_SEL = 2'($urandom);
      ex_branch_taken = ($urandom_range(5) == 0);
      intr_req = ($urandom_range(7) == 0);
      i_flag = ($urandom_range(5) != 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and interrupt sequencer that generates the stall, flush, nop and interupt inputs consumed by the ID/EX control vector register of the pipelined RAT CPU.
- Detects load-use hazards between the ID and EX stages.
- Flushes wrong-path instructions after a taken branch.
- Drains the pipeline before injecting a single interrupt bubble into the ID/EX register.
- Sits beside the decoder and drives the IF/ID register, the PC and the ID/EX register.

Parameters:
BRANCH_FLUSH_CYCLES, 2, total cycles of flush/nop after a taken branch, including the detection cycle (min 1).
INTR_DRAIN_CYCLES, 2, cycles of fetch stall before interrupt injection (min 1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
id_X_ADDR  in  5  source register X of the instruction in ID.
id_Y_ADDR  in  5  source register Y of the instruction in ID.
id_uses_x  in  1  ID instruction reads X.
id_uses_y  in  1  ID instruction reads Y.
ex_WB_ADDR  in  5  destination register of the instruction in EX.
ex_RF_WR  in  1  EX instruction writes the register file.
ex_RF_WR_SEL  in  2  EX write-back source select; LOAD_SEL means data comes from scratch RAM.
ex_branch_taken  in  1  branch or call/ret resolved taken in EX this cycle.
intr_req  in  1  external interrupt request, level or single-cycle pulse.
i_flag  in  1  interrupt enable flag.
pc_stall  out  1  hold PC.
ifid_stall  out  1  hold IF/ID register.
ifid_flush  out  1  load a bubble into IF/ID.
nop  out  1  ID/EX inserts an all-zero control vector.
interupt  out  1  ID/EX loads the interrupt control vector (SP decrement, SCR write, PC_MUX_SEL=10).
intr_ack  out  1  one-cycle acknowledge to the interrupt source.

Behaviour:
- While rst=1: state=RUN, cnt=0, intr_pending=0, and every output is forced to 0.
- Outputs are combinational from registered state plus current inputs, so they take effect in the same cycle.
- load_hazard = ex_RF_WR & (ex_RF_WR_SEL==LOAD_SEL) & ((id_uses_x & id_X_ADDR==ex_WB_ADDR) | (id_uses_y & id_Y_ADDR==ex_WB_ADDR)).
- intr_pending:
  - set at a clock edge when intr_req=1 & i_flag=1;
  - cleared when i_flag=0 while state=RUN;
  - cleared in the INTR_INJ cycle;
  - a one-cycle intr_req pulse is therefore never lost while i_flag=1.
- RUN state, priority branch > load_hazard > interrupt:
  - ex_branch_taken: ifid_flush=1, nop=1. If BRANCH_FLUSH_CYCLES>1, go to FLUSH with cnt=BRANCH_FLUSH_CYCLES-2; otherwise stay in RUN.
  - else load_hazard: pc_stall=1, ifid_stall=1, nop=1; stay in RUN. The stall lasts exactly one cycle because the bubble removes the hazard on the next cycle.
  - else intr_pending & i_flag: pc_stall=1, ifid_flush=1; go to INTR_DRAIN with cnt=INTR_DRAIN_CYCLES-1.
  - else: all outputs 0.
- FLUSH state:
  - ifid_flush=1, nop=1; load_hazard is ignored.
  - cnt==0 -> RUN; otherwise cnt decrements.
  - A new ex_branch_taken reloads cnt=BRANCH_FLUSH_CYCLES-2.
- INTR_DRAIN state:
  - pc_stall=1, ifid_flush=1. nop=1 only if ex_branch_taken.
  - The interrupt is committed; i_flag is no longer checked.
  - ex_branch_taken reloads cnt=INTR_DRAIN_CYCLES-1.
  - cnt==0 -> INTR_INJ; otherwise cnt decrements.
- INTR_INJ state:
  - interupt=1, intr_ack=1, ifid_flush=1, nop=0, pc_stall=0.
  - Exactly one cycle, then -> RUN.
- interupt and nop are never both 1.
- Flush and stall are mutually exclusive on IF/ID; ifid_flush wins.
- cnt width = clog2(max(BRANCH_FLUSH_CYCLES, INTR_DRAIN_CYCLES)+1).
- Reset asserted mid-FLUSH or mid-INTR_DRAIN aborts the sequence and drops intr_pending; no interrupt is delivered afterward.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - typedef enum logic[1:0] {RUN, FLUSH, INTR_DRAIN, INTR_INJ} hazard_state_t;
  - localparam LOAD_SEL = 2'b01;
  - the reg-address width constant (5).
- One sub-module: load_use_detect, purely combinational, producing load_hazard.

Test Plan:
1. ex_RF_WR=1, ex_RF_WR_SEL=01, ex_WB_ADDR=5, id_X_ADDR=5, id_uses_x=1 for one cycle -> pc_stall, ifid_stall and nop all =1 that cycle; all 0 the next cycle once the EX inputs clear.
2. ex_branch_taken pulse with BRANCH_FLUSH_CYCLES=2 -> ifid_flush=nop=1 for exactly 2 cycles, then 0; a simultaneous load_hazard produces no ifid_stall.
3. One-cycle intr_req with i_flag=1 in RUN ->
   - the next cycle enters INTR_DRAIN, with pc_stall=1 for 2 cycles;
   - then interupt=intr_ack=1 for exactly 1 cycle;
   - then all outputs 0.
4. intr_req=1 with i_flag=0 -> no pc_stall, interupt or intr_ack for 10 cycles. Setting i_flag to 1 afterward with intr_req held -> injection sequence starts.
5. ex_branch_taken during the 2nd INTR_DRAIN cycle -> nop=1 that cycle; drain restarts with 2 more pc_stall cycles; interupt fires once only.
6. rst asserted mid-INTR_DRAIN -> all outputs 0 immediately (asynchronous); after release, no interupt for 10 cycles with intr_req=0.
